// File: rtl/sspwm_dt_multi_if.sv
// ---------------------------------------------------------------------------
// sspwm_dt_multi_if
// Purpose : Bundles the control inputs and gate-drive outputs of the
//           multi-channel PWM generator.
// Signals : en        - run carrier (1) / force outputs to safe state (0)
//           load      - strobe: capture period_in/duty_in/dead_in into shadow
//           period_in - carrier top count P (counter runs 0..P)
//           duty_in   - per-channel duty, channel i = [i*CNT_W +: CNT_W]
//           dead_in   - dead-time in clk cycles, common to all channels
//           pwm_hi    - high-side gate drive per channel
//           pwm_lo    - low-side gate drive per channel
//           sync      - 1-cycle pulse marking carrier start
//           load_ack  - 1-cycle pulse: shadow values became active
// Modports: master drives the controls, slave is the PWM generator.
// ---------------------------------------------------------------------------
interface sspwm_dt_multi_if #(
  parameter int CNT_W = 12,
  parameter int NCH   = 3,
  parameter int DT_W  = 8
) ();
  logic                 en;
  logic                 load;
  logic [CNT_W-1:0]     period_in;
  logic [NCH*CNT_W-1:0] duty_in;
  logic [DT_W-1:0]      dead_in;
  logic [NCH-1:0]       pwm_hi;
  logic [NCH-1:0]       pwm_lo;
  logic                 sync;
  logic                 load_ack;

  modport master (
    output en, load, period_in, duty_in, dead_in,
    input  pwm_hi, pwm_lo, sync, load_ack
  );

  modport slave (
    input  en, load, period_in, duty_in, dead_in,
    output pwm_hi, pwm_lo, sync, load_ack
  );
endinterface

// File: rtl/sspwm_dt_multi.sv
// ---------------------------------------------------------------------------
// sspwm_dt_multi
// Purpose : Multi-channel sine-sampled PWM generator. One shared carrier
//           counter feeds NCH comparators; each comparator output passes
//           through a dead-time stage producing complementary gate drives.
//           Period, duty and dead-time are double-buffered and only take
//           effect at the carrier wrap (or continuously while disabled).
// Ports   : clk   - system clock, rising edge
//           rst_n - synchronous reset, active low
//           bus   - sspwm_dt_multi_if.slave (controls in, gate drives out)
// ---------------------------------------------------------------------------
module sspwm_dt_multi #(
  parameter int CNT_W      = 12,
  parameter int NCH        = 3,
  parameter int DT_W       = 8,
  parameter int PERIOD_DEF = 3906
) (
  input  logic               clk,
  input  logic               rst_n,
  sspwm_dt_multi_if.slave    bus
);

  localparam logic [CNT_W-1:0] P_RST = CNT_W'(PERIOD_DEF);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     p_act_q, p_act_d, p_sh_q, p_sh_d;
  logic [NCH*CNT_W-1:0] d_act_q, d_act_d, d_sh_q, d_sh_d;
  logic [DT_W-1:0]      dead_act_q, dead_act_d, dead_sh_q, dead_sh_d;
  logic                 pending_q, pending_d;
  logic                 sync_q, sync_d;
  logic                 ack_q, ack_d;
  logic [CNT_W-1:0]     period_cap;
  logic                 wrap;
  logic                 apply;

  // -------------------------------------------------------------------------
  // Carrier counter and double-buffered parameters
  // -------------------------------------------------------------------------
  always_comb begin
    // A zero period would stall the carrier; the shortest legal one is 0..1.
    period_cap = (bus.period_in == '0) ? CNT_W'(1) : bus.period_in;
    wrap       = bus.en && (cnt_q == p_act_q);
    // Disabled: active follows shadow every cycle. Enabled: only at wrap,
    // and a load arriving on the wrap cycle is taken straight through.
    apply      = !bus.en || (wrap && (pending_q || bus.load));

    cnt_d = '0;
    if (bus.en && !wrap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    p_sh_d    = p_sh_q;
    d_sh_d    = d_sh_q;
    dead_sh_d = dead_sh_q;
    if (bus.load) begin
      p_sh_d    = period_cap;
      d_sh_d    = bus.duty_in;
      dead_sh_d = bus.dead_in;
    end

    p_act_d    = p_act_q;
    d_act_d    = d_act_q;
    dead_act_d = dead_act_q;
    pending_d  = pending_q;
    if (apply) begin
      // Using the shadow next-state gives the load-on-wrap bypass for free.
      p_act_d    = p_sh_d;
      d_act_d    = d_sh_d;
      dead_act_d = dead_sh_d;
      pending_d  = 1'b0;
    end else if (bus.load) begin
      pending_d  = 1'b1;
    end

    sync_d = bus.en && (cnt_q == '0);
    ack_d  = wrap && (pending_q || bus.load);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      p_act_q    <= P_RST;
      p_sh_q     <= P_RST;
      d_act_q    <= '0;
      d_sh_q     <= '0;
      dead_act_q <= '0;
      dead_sh_q  <= '0;
      pending_q  <= 1'b0;
      sync_q     <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      p_act_q    <= p_act_d;
      p_sh_q     <= p_sh_d;
      d_act_q    <= d_act_d;
      d_sh_q     <= d_sh_d;
      dead_act_q <= dead_act_d;
      dead_sh_q  <= dead_sh_d;
      pending_q  <= pending_d;
      sync_q     <= sync_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.sync     = sync_q;
  assign bus.load_ack = ack_q;

  // -------------------------------------------------------------------------
  // Per-channel comparator and dead-time stage
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic            raw;
    logic            same;
    logic            expired;
    logic            keep;
    logic            on;
    logic [DT_W-1:0] held;
    logic            hi_q, hi_d;
    logic            lo_q, lo_d;
    logic            raw_prev_q, raw_prev_d;
    logic [DT_W-1:0] dcnt_q, dcnt_d;

    always_comb begin
      // D = 0 never passes, D > P always passes, so no wrap glitch exists.
      raw     = cnt_q < d_act_q[gi*CNT_W +: CNT_W];
      same    = (raw == raw_prev_q);
      // held = number of earlier consecutive cycles at this raw level,
      // saturated at the dead-time; an edge restarts it from zero.
      held    = same ? dcnt_q : '0;
      expired = (held >= dead_act_q);
      // An already-driven output stays on while raw holds, so a dead-time
      // increase applied at a wrap cannot chop a level that is already on.
      keep    = same && (raw ? hi_q : lo_q);
      on      = expired || keep;

      hi_d       = 1'b0;
      lo_d       = 1'b0;
      dcnt_d     = '0;
      raw_prev_d = raw;
      if (bus.en) begin
        hi_d   = raw && on;
        lo_d   = !raw && on;
        dcnt_d = expired ? dead_act_q : held + DT_W'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        hi_q       <= 1'b0;
        lo_q       <= 1'b0;
        raw_prev_q <= 1'b0;
        dcnt_q     <= '0;
      end else begin
        hi_q       <= hi_d;
        lo_q       <= lo_d;
        raw_prev_q <= raw_prev_d;
        dcnt_q     <= dcnt_d;
      end
    end

    assign bus.pwm_hi[gi] = hi_q;
    assign bus.pwm_lo[gi] = lo_q;
  end

endmodule

// File: tb/tb_sspwm_dt_multi.sv
// ---------------------------------------------------------------------------
// tb_sspwm_dt_multi
// Scoreboarded bench: the stimulus process advances a behavioural model once
// per clock and queues the outputs expected after that edge; a monitor pops
// and compares every cycle. Directed scenarios plus randomized configs.
// ---------------------------------------------------------------------------
module tb_sspwm_dt_multi;
  localparam int CNT_W = 12;
  localparam int NCH   = 3;
  localparam int DT_W  = 8;
  localparam int PDEF  = 3906;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sspwm_dt_multi_if #(.CNT_W(CNT_W), .NCH(NCH), .DT_W(DT_W)) bus ();

  sspwm_dt_multi #(
    .CNT_W(CNT_W), .NCH(NCH), .DT_W(DT_W), .PERIOD_DEF(PDEF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] hi;
    logic [NCH-1:0] lo;
    logic           sync;
    logic           ack;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // ---------------- behavioural reference model ----------------
  // State mirrors what the spec calls active/shadow values; m_run is the
  // length of the current constant-raw stretch since the channel was enabled.
  int m_cnt, m_p, m_sp, m_dead, m_sdead;
  int m_d[NCH], m_sd[NCH];
  bit m_pend;
  int m_run[NCH];
  bit m_lastraw[NCH];
  bit m_on[NCH];

  task automatic model_reset();
    m_cnt = 0; m_p = PDEF; m_sp = PDEF; m_dead = 0; m_sdead = 0; m_pend = 0;
    for (int i = 0; i < NCH; i++) begin
      m_d[i] = 0; m_sd[i] = 0; m_run[i] = 0; m_lastraw[i] = 0; m_on[i] = 0;
    end
  endtask

  task automatic model_step();
    exp_t e;
    int   pin;
    int   din[NCH];
    bit   wrap, apply, raw;
    e = '0;
    if (!rst_n) begin
      model_reset();
    end else begin
      pin = (bus.period_in == 0) ? 1 : int'(bus.period_in);
      for (int i = 0; i < NCH; i++) din[i] = int'(bus.duty_in[i*CNT_W +: CNT_W]);
      wrap = bus.en && (m_cnt == m_p);
      for (int ch = 0; ch < NCH; ch++) begin
        raw = (m_cnt < m_d[ch]);
        if (bus.en) begin
          m_run[ch]     = (m_run[ch] > 0 && raw == m_lastraw[ch]) ? m_run[ch] + 1 : 1;
          m_lastraw[ch] = raw;
          // asserting side comes on once raw has held dead+1 cycles,
          // and stays on while raw keeps holding
          m_on[ch]      = (m_run[ch] >= m_dead + 1) || (m_run[ch] > 1 && m_on[ch]);
          e.hi[ch]      = raw && m_on[ch];
          e.lo[ch]      = !raw && m_on[ch];
        end else begin
          m_run[ch] = 0;
          m_on[ch]  = 0;
        end
      end
      e.sync = bus.en && (m_cnt == 0);
      e.ack  = wrap && (m_pend || bus.load);
      apply  = !bus.en || (wrap && (m_pend || bus.load));
      if (bus.load) begin
        m_sp = pin; m_sd = din; m_sdead = int'(bus.dead_in);
      end
      if (apply) begin
        m_p = m_sp; m_d = m_sd; m_dead = m_sdead; m_pend = 0;
      end else if (bus.load) begin
        m_pend = 1;
      end
      m_cnt = (!bus.en || wrap) ? 0 : m_cnt + 1;
    end
    exp_q.push_back(e);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_inputs(input int p, input int a, input int b, input int c, input int dead);
    bus.period_in = CNT_W'(p);
    bus.duty_in   = {CNT_W'(c), CNT_W'(b), CNT_W'(a)};
    bus.dead_in   = DT_W'(dead);
  endtask

  // program while disabled, then enable
  task automatic cfg_off(input int p, input int a, input int b, input int c, input int dead);
    $display("cfg (disabled) P=%0d D={%0d,%0d,%0d} dead=%0d", p, a, b, c, dead);
    bus.en = 1'b0;
    bus.load = 1'b1;
    set_inputs(p, a, b, c, dead);
    step();
    bus.load = 1'b0;
    step();
    bus.en = 1'b1;
  endtask

  // shadow load while running, issued in the cycle where cnt == at
  task automatic load_at(input int at, input int p, input int a, input int b, input int c, input int dead);
    for (int k = 0; k < 5000 && m_cnt != at; k++) step();
    if (m_cnt != at) begin
      vectors++;
      miscompares++;
      $display("FAIL load_wait cnt=%0d required=%0d", m_cnt, at);
    end
    $display("load (running) at cnt=%0d P=%0d D={%0d,%0d,%0d} dead=%0d", at, p, a, b, c, dead);
    bus.load = 1'b1;
    set_inputs(p, a, b, c, dead);
    step();
    bus.load = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e        = exp_q.pop_front();
        act.hi   = bus.pwm_hi;
        act.lo   = bus.pwm_lo;
        act.sync = bus.sync;
        act.ack  = bus.load_ack;
        vectors++;
        if (act !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got hi=%b lo=%b sync=%b ack=%b required hi=%b lo=%b sync=%b ack=%b",
                   $time, act.hi, act.lo, act.sync, act.ack, e.hi, e.lo, e.sync, e.ack);
        end
        vectors++;
        if ((bus.pwm_hi & bus.pwm_lo) !== '0) begin
          miscompares++;
          $display("FAIL overlap t=%0t got hi&lo=%b required 0", $time, bus.pwm_hi & bus.pwm_lo);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int p, a, b, c, dd;
    model_reset();
    bus.en = 1'b0; bus.load = 1'b0;
    set_inputs(0, 0, 0, 0, 0);

    // T1: reset, default period, mid-run reset
    $display("T1 reset");
    run(3);
    rst_n = 1'b1;
    bus.en = 1'b1;
    run(60);
    rst_n = 1'b0;
    run(3);
    rst_n = 1'b1;
    run(20);

    // T2: basic duty, no dead-time
    $display("T2 basic duty");
    cfg_off(99, 25, 60, 0, 0);
    run(250);

    // T3: dead-time
    $display("T3 dead-time");
    cfg_off(99, 50, 50, 99, 5);
    run(250);

    // T4: boundaries and short pulses swallowed by dead-time
    $display("T4 boundaries");
    cfg_off(99, 0, 100, 3, 5);
    run(220);
    for (int k = 0; k < 6; k++) begin
      load_at(50, 99, (k % 2) ? 3 : 0, 100, 3, 5);
      run(80);
    end

    // T5: double buffering
    $display("T5 double-buffer");
    cfg_off(99, 30, 30, 30, 2);
    run(50);
    load_at(40, 99, 10, 30, 30, 2);
    run(150);
    load_at(99, 99, 70, 30, 30, 2);
    run(150);

    // T6: enable mid-pulse, minimum period, independent channels
    $display("T6 enable/period");
    cfg_off(99, 10, 50, 90, 3);
    run(130);
    for (int k = 0; k < 500 && m_cnt != 5; k++) step();
    bus.en = 1'b0;
    run(5);
    bus.en = 1'b1;
    run(120);
    cfg_off(0, 1, 0, 5, 0);
    run(20);

    // randomized configurations
    $display("R randomized");
    for (int it = 0; it < 14; it++) begin
      p  = $urandom_range(150, 1);
      a  = $urandom_range(p + 2, 0);
      b  = $urandom_range(p + 2, 0);
      c  = $urandom_range(p + 2, 0);
      dd = $urandom_range(12, 0);
      if ($urandom_range(1, 0) == 0) cfg_off(p, a, b, c, dd);
      else load_at($urandom_range(m_p, 0), p, a, b, c, dd);
      run($urandom_range(400, 50));
      if ($urandom_range(3, 0) == 0) begin
        bus.en = 1'b0;
        run($urandom_range(5, 1));
        bus.en = 1'b1;
        run($urandom_range(200, 20));
      end
    end

    @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
